ysyx_lsu: RTL and testbench
===========================

YSYX_LSU -- requirements
Module: ysyx_lsu

Interface
REQ-001 SHALL have parameter BIT_W, default 32, the data/address width (only 32 supported).
REQ-002 SHALL have clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have rst  input  1  reset; synchronous, active-high; clock clk.
REQ-004 SHALL have avalid_i  input  1  EXU request valid, held until response.
REQ-005 SHALL have ren_i / wen_i  input  1 each  load / store select; never both high.
REQ-006 SHALL have addr_i  input  BIT_W  byte address.
REQ-007 SHALL have wdata_i  input  BIT_W  store data, right-aligned.
REQ-008 SHALL have func3_i  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have rdata_o  output  BIT_W  extended load data; rvalid_o / wready_o  output  1 each  load / store done pulses; fault_o  output  1  error pulse.
REQ-010 SHALL have read bus: arvalid_o out 1, araddr_o out BIT_W, arready_i in 1, rvalid_i in 1, rdata_i in BIT_W, rresp_i in 2, rready_o out 1.
REQ-011 SHALL have write bus: awvalid_o out 1, awaddr_o out BIT_W, awready_i in 1, wvalid_o out 1, wdata_o out BIT_W, wstrb_o out 4, wready_i in 1, bvalid_i in 1, bresp_i in 2, bready_o out 1.

Function
REQ-012 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-013 SHALL accept a request only in IDLE with avalid_i=1, latching addr, wdata, func3, ren/wen; requests in other states are ignored.
REQ-014 SHALL go IDLE->RD_ADDR on load, IDLE->WR_REQ on store.
REQ-015 SHALL drive arvalid_o=1 in RD_ADDR; on arready_i go RD_DATA; rready_o=1 only in RD_DATA; on rvalid_i latch data/resp, go DONE.
REQ-016 SHALL in WR_REQ raise awvalid_o and wvalid_o together, drop each independently after its handshake, go WR_RESP once both done (same cycle allowed).
REQ-017 SHALL drive bready_o=1 only in WR_RESP; on bvalid_i latch resp, go DONE.
REQ-018 SHALL in DONE pulse rvalid_o (load) or wready_o (store) for exactly one cycle, then return to IDLE; earliest next accept is cycle after DONE.
REQ-019 SHALL drive araddr_o/awaddr_o = latched address, stable while valid high.
REQ-020 SHALL set wstrb_o = 0001 (B), 0011 (H), 1111 (W) shifted left by addr[1:0], truncated to 4 bits; wdata_o = wdata shifted left by 8*addr[1:0].
REQ-021 SHALL form rdata_o from rdata_i shifted right by 8*addr[1:0], sign-extended (B,H) or zero-extended (BU,HU,W); rdata_o held until next accept.
REQ-022 SHALL on nonzero rresp/bresp assert fault_o with the DONE pulse and force rdata_o=0.
REQ-023 SHALL keep minimum latency accept->DONE of 3 cycles for load and store with zero-wait bus.

Reset
REQ-024 SHALL on rst force state IDLE and all valid/ready/strobe outputs, rdata_o and fault_o to 0 at next edge, including mid-transaction; in-flight response is dropped.

Configuration
REQ-025 SHALL honour macro YSYX_LSU_ALIGN_CHECK_EN.
REQ-026 SHALL, when defined, detect misaligned (H/HU/SH with addr[0]=1; W with addr[1:0]!=0), issue no bus transaction, go IDLE->DONE directly, pulse rvalid_o/wready_o with fault_o=1, rdata_o=0.
REQ-027 SHALL, when undefined, issue misaligned accesses unchanged per REQ-020/021, bytes beyond word dropped, fault_o only from bus responses.

Verification
REQ-028 LW addr 0x8000_0004, rdata_i 0xDEAD_BEEF, zero-wait -> araddr 0x8000_0004, rdata_o 0xDEAD_BEEF, rvalid_o one-cycle pulse 3 cycles after accept.
REQ-029 LB addr 0x...03, rdata_i 0x8012_3456 -> rdata_o 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-030 SH addr 0x...02 wdata 0x0000_ABCD, awready 2 cycles before wready -> wstrb 1100, wdata_o 0xABCD_0000, wready_o pulse once after bvalid.
REQ-031 LW with rresp=2 -> fault_o=1, rdata_o=0 with rvalid_o pulse.
REQ-032 rst asserted in RD_DATA -> all outputs 0 next cycle, state IDLE, new LW accepted after rst.
REQ-033 With YSYX_LSU_ALIGN_CHECK_EN, LW addr 0x...02 -> no arvalid, fault_o+rvalid_o pulse 1 cycle after accept; without it -> arvalid issued.

Source files
------------

// File: rtl/ysyx_lsu.sv
// Load/store unit: turns one EXU request into an AXI-lite style read or write, aligns data and strobes.
// Optional build macro YSYX_LSU_ALIGN_CHECK_EN: misaligned H/W accesses fault without touching the bus.
module ysyx_lsu #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             avalid_i,
    input  logic             ren_i,
    input  logic             wen_i,
    input  logic [BIT_W-1:0] addr_i,
    input  logic [BIT_W-1:0] wdata_i,
    input  logic [2:0]       func3_i,
    output logic [BIT_W-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             wready_o,
    output logic             fault_o,
    output logic             arvalid_o,
    output logic [BIT_W-1:0] araddr_o,
    input  logic             arready_i,
    input  logic             rvalid_i,
    input  logic [BIT_W-1:0] rdata_i,
    input  logic [1:0]       rresp_i,
    output logic             rready_o,
    output logic             awvalid_o,
    output logic [BIT_W-1:0] awaddr_o,
    input  logic             awready_i,
    output logic             wvalid_o,
    output logic [BIT_W-1:0] wdata_o,
    output logic [3:0]       wstrb_o,
    input  logic             wready_i,
    input  logic             bvalid_i,
    input  logic [1:0]       bresp_i,
    output logic             bready_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]       state_reg;
    logic [BIT_W-1:0] addr_reg;
    logic [BIT_W-1:0] wdata_reg;
    logic [2:0]       func3_reg;
    logic             is_load_reg;
    logic             aw_done_reg;
    logic             w_done_reg;
    logic             fault_reg;
    logic [BIT_W-1:0] rdata_reg;

    logic             misaligned;
    logic             aw_hs;
    logic             w_hs;
    logic [BIT_W-1:0] shifted_rdata;
    logic [BIT_W-1:0] ext_rdata;
    logic [3:0]       base_strb;

`ifdef YSYX_LSU_ALIGN_CHECK_EN
    assign misaligned = (func3_i[1:0] == 2'b01 && addr_i[0]) ||
                        (func3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign aw_hs = awvalid_o && awready_i;
    assign w_hs  = wvalid_o && wready_i;

    // Bytes shifted past the top of the word are simply lost on misaligned accesses.
    assign shifted_rdata = rdata_i >> {addr_reg[1:0], 3'b000};

    always_comb begin
        ext_rdata = shifted_rdata;
        case (func3_reg)
            3'b000:  ext_rdata = {{(BIT_W-8){shifted_rdata[7]}}, shifted_rdata[7:0]};
            3'b001:  ext_rdata = {{(BIT_W-16){shifted_rdata[15]}}, shifted_rdata[15:0]};
            3'b100:  ext_rdata = {{(BIT_W-8){1'b0}}, shifted_rdata[7:0]};
            3'b101:  ext_rdata = {{(BIT_W-16){1'b0}}, shifted_rdata[15:0]};
            default: ext_rdata = shifted_rdata;
        endcase
    end

    always_comb begin
        base_strb = 4'b1111;
        case (func3_reg[1:0])
            2'b00:   base_strb = 4'b0001;
            2'b01:   base_strb = 4'b0011;
            default: base_strb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            func3_reg   <= '0;
            is_load_reg <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            fault_reg   <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (avalid_i && (ren_i || wen_i)) begin
                        addr_reg    <= addr_i;
                        wdata_reg   <= wdata_i;
                        func3_reg   <= func3_i;
                        is_load_reg <= ren_i;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        fault_reg   <= misaligned;
                        if (misaligned) begin
                            rdata_reg <= '0;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= ren_i ? RD_ADDR : WR_REQ;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready_i) state_reg <= RD_DATA;
                end
                RD_DATA: begin
                    if (rvalid_i) begin
                        fault_reg <= (rresp_i != 2'b00);
                        rdata_reg <= (rresp_i != 2'b00) ? '0 : ext_rdata;
                        state_reg <= DONE;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done_reg <= 1'b1;
                    if (w_hs)  w_done_reg  <= 1'b1;
                    if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_reg <= WR_RESP;
                end
                WR_RESP: begin
                    if (bvalid_i) begin
                        fault_reg <= (bresp_i != 2'b00);
                        if (bresp_i != 2'b00) rdata_reg <= '0;
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign arvalid_o = (state_reg == RD_ADDR);
    assign araddr_o  = addr_reg;
    assign rready_o  = (state_reg == RD_DATA);
    assign awvalid_o = (state_reg == WR_REQ) && !aw_done_reg;
    assign awaddr_o  = addr_reg;
    assign wvalid_o  = (state_reg == WR_REQ) && !w_done_reg;
    assign wdata_o   = wdata_reg << {addr_reg[1:0], 3'b000};
    assign wstrb_o   = wvalid_o ? (base_strb << addr_reg[1:0]) : 4'b0000;
    assign bready_o  = (state_reg == WR_RESP);
    assign rvalid_o  = (state_reg == DONE) && is_load_reg;
    assign wready_o  = (state_reg == DONE) && !is_load_reg;
    assign fault_o   = (state_reg == DONE) && fault_reg;
    assign rdata_o   = rdata_reg;
endmodule

// File: tb/tb_ysyx_lsu.sv
// Scoreboard bench for ysyx_lsu with a reactive bus slave whose handshake delays are set per test.
module tb_ysyx_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        avalid_i, ren_i, wen_i;
    logic [31:0] addr_i, wdata_i;
    logic [2:0]  func3_i;
    logic [31:0] rdata_o;
    logic        rvalid_o, wready_o, fault_o;
    logic        arvalid_o, arready_i, rvalid_i, rready_o;
    logic [31:0] araddr_o, rdata_i;
    logic [1:0]  rresp_i, bresp_i;
    logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
    logic [31:0] awaddr_o, wdata_o;
    logic [3:0]  wstrb_o;

    int checks = 0;
    int errors = 0;

    // slave configuration
    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] rd_value = '0;
    logic [1:0]  rresp_val = 2'b00, bresp_val = 2'b00;

    // recorded handshakes
    int          ar_hs_cnt = 0;
    logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    typedef struct {
        logic        is_load;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    ysyx_lsu #(.BIT_W(32)) dut (
        .clk(clk), .rst(rst),
        .avalid_i(avalid_i), .ren_i(ren_i), .wen_i(wen_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .func3_i(func3_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .wready_o(wready_o), .fault_o(fault_o),
        .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o),
        .awvalid_o(awvalid_o), .awaddr_o(awaddr_o), .awready_i(awready_i),
        .wvalid_o(wvalid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wready_i(wready_i),
        .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o)
    );

    always #5 clk = ~clk;

    assign arready_i = arvalid_o && (ar_cnt >= ar_delay);
    assign rvalid_i  = rready_o  && (r_cnt  >= r_delay);
    assign awready_i = awvalid_o && (aw_cnt >= aw_delay);
    assign wready_i  = wvalid_o  && (w_cnt  >= w_delay);
    assign bvalid_i  = bready_o  && (b_cnt  >= b_delay);
    assign rdata_i   = rd_value;
    assign rresp_i   = rresp_val;
    assign bresp_i   = bresp_val;

    always @(posedge clk) begin
        ar_cnt <= (arvalid_o && !arready_i) ? ar_cnt + 1 : 0;
        r_cnt  <= (rready_o  && !rvalid_i)  ? r_cnt + 1  : 0;
        aw_cnt <= (awvalid_o && !awready_i) ? aw_cnt + 1 : 0;
        w_cnt  <= (wvalid_o  && !wready_i)  ? w_cnt + 1  : 0;
        b_cnt  <= (bready_o  && !bvalid_i)  ? b_cnt + 1  : 0;
        if (arvalid_o && arready_i) begin
            ar_hs_cnt   <= ar_hs_cnt + 1;
            last_araddr <= araddr_o;
        end
        if (awvalid_o && awready_i) last_awaddr <= awaddr_o;
        if (wvalid_o && wready_i) begin
            last_wdata <= wdata_o;
            last_wstrb <= wstrb_o;
        end
    end

    task automatic run_txn(input logic load, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [31:0] exp_rdata,
                           input logic exp_fault, input int exp_lat, input string name);
        exp_t e;
        int   cnt;
        logic seen;
        e.is_load = load;
        e.rdata   = exp_rdata;
        e.fault   = exp_fault;
        e.lat     = exp_lat;
        sb_q.push_back(e);
        @(negedge clk);
        avalid_i = 1'b1; ren_i = load; wen_i = !load;
        addr_i = addr; wdata_i = wdata; func3_i = f3;
        cnt = 0;
        seen = 1'b0;
        while (!seen && cnt < 60) begin
            @(negedge clk);
            cnt++;
            if (rvalid_o || wready_o) seen = 1'b1;
        end
        avalid_i = 1'b0; ren_i = 1'b0; wen_i = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no done pulse after %0d cycles, required %0d", name, cnt, e.lat);
        end else begin
            checks++;
            if ({rvalid_o, wready_o} !== {e.is_load, !e.is_load}) begin
                errors++;
                $display("FAIL %s kind: rvalid/wready=%b%b required %b%b", name, rvalid_o, wready_o,
                         e.is_load, !e.is_load);
            end
            checks++;
            if (fault_o !== e.fault) begin
                errors++;
                $display("FAIL %s fault: got %b required %b", name, fault_o, e.fault);
            end
            if (e.is_load) begin
                checks++;
                if (rdata_o !== e.rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got %h required %h", name, rdata_o, e.rdata);
                end
            end
            if (cnt != e.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, cnt, e.lat);
            end
            @(negedge clk);
            checks++;
            if ({rvalid_o, wready_o, fault_o} !== 3'b000) begin
                errors++;
                $display("FAIL %s pulse width: rvalid/wready/fault=%b%b%b required 000", name,
                         rvalid_o, wready_o, fault_o);
            end
        end
        $display("txn %s addr=%h f3=%b lat=%0d rdata=%h fault=%b", name, addr, f3, cnt, rdata_o, e.fault);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({arvalid_o, rready_o, awvalid_o, wvalid_o, wstrb_o, bready_o, rvalid_o, wready_o,
             fault_o, rdata_o} !== '0) begin
            errors++;
            $display("FAIL %s outputs: arv=%b rrdy=%b awv=%b wv=%b strb=%b brdy=%b rv=%b wr=%b flt=%b rdata=%h required all 0",
                     name, arvalid_o, rready_o, awvalid_o, wvalid_o, wstrb_o, bready_o, rvalid_o,
                     wready_o, fault_o, rdata_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_lw();
        rd_value = 32'hDEAD_BEEF;
        run_txn(1'b1, 32'h8000_0004, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 3, "lw");
        checks++;
        if (last_araddr !== 32'h8000_0004) begin
            errors++;
            $display("FAIL lw araddr: got %h required 80000004", last_araddr);
        end
    endtask

    task automatic test_lb();
        rd_value = 32'h8012_3456;
        run_txn(1'b1, 32'h8000_0003, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0, 3, "lb");
        run_txn(1'b1, 32'h8000_0003, 32'h0, 3'b100, 32'h0000_0080, 1'b0, 3, "lbu");
    endtask

    task automatic test_sh();
        aw_delay = 0; w_delay = 2; b_delay = 1;
        run_txn(1'b0, 32'h8000_0002, 32'h0000_ABCD, 3'b001, 32'h0, 1'b0, 6, "sh");
        aw_delay = 0; w_delay = 0; b_delay = 0;
        checks++;
        if (last_wstrb !== 4'b1100 || last_wdata !== 32'hABCD_0000 || last_awaddr !== 32'h8000_0002) begin
            errors++;
            $display("FAIL sh bus: strb=%b wdata=%h awaddr=%h required 1100 abcd0000 80000002",
                     last_wstrb, last_wdata, last_awaddr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s_addr[2], s_data[2], s_exp[2];
        logic [3:0]  s_strb[2];
        logic [2:0]  s_f3[2];
        logic [31:0] l_addr[5], l_in[5], l_exp[5];
        logic [2:0]  l_f3[5];
        s_addr = '{32'h8000_0001, 32'h8000_0008};
        s_data = '{32'h0000_0012, 32'h1234_5678};
        s_f3   = '{3'b000, 3'b010};
        s_strb = '{4'b0010, 4'b1111};
        s_exp  = '{32'h0000_1200, 32'h1234_5678};
        l_addr = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000};
        l_f3   = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b000};
        l_in   = '{32'h8012_3456, 32'h8012_F456, 32'h8012_3456, 32'h0000_00FF, 32'h0000_00FF};
        l_exp  = '{32'hFFFF_8012, 32'h0000_F456, 32'h0000_0034, 32'h0000_00FF, 32'hFFFF_FFFF};
        for (int i = 0; i < 2; i++) begin
            aw_delay = $urandom_range(0, 2);
            w_delay  = $urandom_range(0, 2);
            b_delay  = $urandom_range(0, 2);
            run_txn(1'b0, s_addr[i], s_data[i], s_f3[i], 32'h0, 1'b0,
                    3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay, "b2b_store");
            checks++;
            if (last_wstrb !== s_strb[i] || last_wdata !== s_exp[i]) begin
                errors++;
                $display("FAIL b2b_store %0d bus: strb=%b wdata=%h required %b %h", i,
                         last_wstrb, last_wdata, s_strb[i], s_exp[i]);
            end
        end
        aw_delay = 0; w_delay = 0; b_delay = 0;
        for (int i = 0; i < 5; i++) begin
            ar_delay = $urandom_range(0, 2);
            r_delay  = $urandom_range(0, 2);
            rd_value = l_in[i];
            run_txn(1'b1, l_addr[i], 32'h0, l_f3[i], l_exp[i], 1'b0, 3 + ar_delay + r_delay, "b2b_load");
        end
        ar_delay = 0; r_delay = 0;
    endtask

    task automatic test_rst_mid();
        r_delay  = 5;
        rd_value = 32'h5555_AAAA;
        @(negedge clk);
        avalid_i = 1'b1; ren_i = 1'b1; wen_i = 1'b0;
        addr_i = 32'h8000_0010; func3_i = 3'b010;
        repeat (2) @(negedge clk);
        checks++;
        if (rready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid precondition: rready_o=%b required 1", rready_o);
        end
        rst = 1'b1;
        avalid_i = 1'b0; ren_i = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        r_delay = 0;
        $display("txn rst_mid reset applied in RD_DATA");
        rd_value = 32'h0BAD_F00D;
        run_txn(1'b1, 32'h8000_0014, 32'h0, 3'b010, 32'h0BAD_F00D, 1'b0, 3, "lw_after_rst");
    endtask

    task automatic test_fault();
        rd_value  = 32'h1234_5678;
        rresp_val = 2'b10;
        run_txn(1'b1, 32'h8000_0020, 32'h0, 3'b010, 32'h0, 1'b1, 3, "lw_rresp");
        rresp_val = 2'b00;
        bresp_val = 2'b01;
        run_txn(1'b0, 32'h8000_0024, 32'hCAFE_0001, 3'b010, 32'h0, 1'b1, 3, "sw_bresp");
        bresp_val = 2'b00;
    endtask

    task automatic test_misalign();
        int ar_before;
        rd_value  = 32'h1122_3344;
        ar_before = ar_hs_cnt;
`ifdef YSYX_LSU_ALIGN_CHECK_EN
        run_txn(1'b1, 32'h8000_0002, 32'h0, 3'b010, 32'h0, 1'b1, 1, "lw_misaligned");
        checks++;
        if (ar_hs_cnt != ar_before) begin
            errors++;
            $display("FAIL lw_misaligned bus: ar handshakes=%0d required 0", ar_hs_cnt - ar_before);
        end
`else
        run_txn(1'b1, 32'h8000_0002, 32'h0, 3'b010, 32'h0000_1122, 1'b0, 3, "lw_misaligned");
        checks++;
        if (ar_hs_cnt != ar_before + 1 || last_araddr !== 32'h8000_0002) begin
            errors++;
            $display("FAIL lw_misaligned bus: ar handshakes=%0d araddr=%h required 1 80000002",
                     ar_hs_cnt - ar_before, last_araddr);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        avalid_i = 1'b0; ren_i = 1'b0; wen_i = 1'b0;
        addr_i = '0; wdata_i = '0; func3_i = '0;
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_back_to_back();
        test_rst_mid();
        test_fault();
        test_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
